// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: IDLE -> SERVE -> PLAY -> POINT -> ... -> GAME_OVER.
// Buttons are synchronised and edge-detected; outputs are registered Moore decodes of the next state.
module pong_game_sequencer #(
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int FCNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               serve_btn_n,
   input  logic               restart_btn_n,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               ball_reset,
   output logic               ball_en,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SERVE     = 3'd1;
   localparam logic [2:0] ST_PLAY      = 3'd2;
   localparam logic [2:0] ST_POINT     = 3'd3;
   localparam logic [2:0] ST_GAME_OVER = 3'd4;

   localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
   localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

   logic serve_meta_q, serve_meta_d;
   logic serve_sync_q, serve_sync_d;
   logic serve_prev_q, serve_prev_d;
   logic restart_meta_q, restart_meta_d;
   logic restart_sync_q, restart_sync_d;
   logic restart_prev_q, restart_prev_d;

   logic [2:0]         state_q, state_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [SCORE_W-1:0] score_p1_q, score_p1_d;
   logic [SCORE_W-1:0] score_p2_q, score_p2_d;
   logic               serve_dir_q, serve_dir_d;
   logic               winner_q, winner_d;
   logic               ball_reset_q, ball_reset_d;
   logic               ball_en_q, ball_en_d;
   logic               game_over_q, game_over_d;

   logic               serve_press;
   logic               restart_press;
   logic [SCORE_W-1:0] p1_inc;
   logic [SCORE_W-1:0] p2_inc;

   // Buttons are active-low, so a press is a falling edge of the synchronised level.
   assign serve_press   = serve_prev_q & ~serve_sync_q;
   assign restart_press = restart_prev_q & ~restart_sync_q;
   assign p1_inc        = score_p1_q + SCORE_W'(1);
   assign p2_inc        = score_p2_q + SCORE_W'(1);

   always_comb begin
      serve_meta_d   = serve_btn_n;
      serve_sync_d   = serve_meta_q;
      serve_prev_d   = serve_sync_q;
      restart_meta_d = restart_btn_n;
      restart_sync_d = restart_meta_q;
      restart_prev_d = restart_sync_q;

      state_d     = state_q;
      fcnt_d      = fcnt_q;
      score_p1_d  = score_p1_q;
      score_p2_d  = score_p2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;

      if (restart_press) begin
         state_d     = ST_IDLE;
         fcnt_d      = '0;
         score_p1_d  = '0;
         score_p2_d  = '0;
         serve_dir_d = 1'b1;
         winner_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (serve_press) state_d = ST_SERVE;
            end
            ST_SERVE: begin
               if (frame_tick) begin
                  if (fcnt_q >= SERVE_LAST) state_d = ST_PLAY;
                  else                      fcnt_d  = fcnt_q + FCNT_W'(1);
               end
            end
            ST_PLAY: begin
               // miss_left takes precedence when both sides report a miss together.
               if (miss_left) begin
                  score_p2_d  = p2_inc;
                  serve_dir_d = 1'b0;
                  if (p2_inc == WIN_VAL) begin
                     state_d  = ST_GAME_OVER;
                     winner_d = 1'b1;
                  end else begin
                     state_d  = ST_POINT;
                  end
               end else if (miss_right) begin
                  score_p1_d  = p1_inc;
                  serve_dir_d = 1'b1;
                  if (p1_inc == WIN_VAL) begin
                     state_d  = ST_GAME_OVER;
                     winner_d = 1'b0;
                  end else begin
                     state_d  = ST_POINT;
                  end
               end
            end
            ST_POINT: begin
               if (frame_tick) begin
                  if (fcnt_q >= POINT_LAST) state_d = ST_SERVE;
                  else                      fcnt_d  = fcnt_q + FCNT_W'(1);
               end
            end
            ST_GAME_OVER: begin
               state_d = ST_GAME_OVER;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // A tick landing on the transition cycle is discarded with the old count.
      if (state_d != state_q) fcnt_d = '0;

      ball_reset_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_GAME_OVER);
      ball_en_d    = (state_d == ST_PLAY);
      game_over_d  = (state_d == ST_GAME_OVER);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         serve_meta_q   <= 1'b1;
         serve_sync_q   <= 1'b1;
         serve_prev_q   <= 1'b1;
         restart_meta_q <= 1'b1;
         restart_sync_q <= 1'b1;
         restart_prev_q <= 1'b1;
         state_q        <= ST_IDLE;
         fcnt_q         <= '0;
         score_p1_q     <= '0;
         score_p2_q     <= '0;
         serve_dir_q    <= 1'b1;
         winner_q       <= 1'b0;
         ball_reset_q   <= 1'b1;
         ball_en_q      <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         serve_meta_q   <= serve_meta_d;
         serve_sync_q   <= serve_sync_d;
         serve_prev_q   <= serve_prev_d;
         restart_meta_q <= restart_meta_d;
         restart_sync_q <= restart_sync_d;
         restart_prev_q <= restart_prev_d;
         state_q        <= state_d;
         fcnt_q         <= fcnt_d;
         score_p1_q     <= score_p1_d;
         score_p2_q     <= score_p2_d;
         serve_dir_q    <= serve_dir_d;
         winner_q       <= winner_d;
         ball_reset_q   <= ball_reset_d;
         ball_en_q      <= ball_en_d;
         game_over_q    <= game_over_d;
      end
   end

   assign state      = state_q;
   assign score_p1   = score_p1_q;
   assign score_p2   = score_p2_q;
   assign serve_dir  = serve_dir_q;
   assign winner     = winner_q;
   assign ball_reset = ball_reset_q;
   assign ball_en    = ball_en_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer: per-cycle vector table plus async-reset sequences.
module tb_pong_game_sequencer;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_POINT = 3'd3;
   localparam logic [2:0] S_GO    = 3'd4;

   logic       clk;
   logic       rst;
   logic       frame_tick;
   logic       serve_btn_n;
   logic       restart_btn_n;
   logic       miss_left;
   logic       miss_right;
   logic       ball_reset;
   logic       ball_en;
   logic       serve_dir;
   logic [3:0] score_p1;
   logic [3:0] score_p2;
   logic       game_over;
   logic       winner;
   logic [2:0] state;

   pong_game_sequencer #(
      .WIN_SCORE   (3),
      .SCORE_W     (4),
      .SERVE_FRAMES(4),
      .POINT_FRAMES(2),
      .FCNT_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .serve_btn_n  (serve_btn_n),
      .restart_btn_n(restart_btn_n),
      .miss_left    (miss_left),
      .miss_right   (miss_right),
      .ball_reset   (ball_reset),
      .ball_en      (ball_en),
      .serve_dir    (serve_dir),
      .score_p1     (score_p1),
      .score_p2     (score_p2),
      .game_over    (game_over),
      .winner       (winner),
      .state        (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       sn;
      logic       rn;
      logic       tk;
      logic       ml;
      logic       mr;
      logic [2:0] st;
      logic [3:0] p1;
      logic [3:0] p2;
      logic       dir;
      logic       win;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic add(input logic sn, rn, tk, ml, mr, input logic [2:0] st,
                      input int p1, p2, input logic dir, win);
      vec_t v;
      v.sn = sn; v.rn = rn; v.tk = tk; v.ml = ml; v.mr = mr;
      v.st = st; v.p1 = 4'(p1); v.p2 = 4'(p2); v.dir = dir; v.win = win;
      vq.push_back(v);
   endtask

   task automatic addn(input int n, input logic sn, rn, tk, ml, mr, input logic [2:0] st,
                       input int p1, p2, input logic dir, win);
      for (int k = 0; k < n; k++) add(sn, rn, tk, ml, mr, st, p1, p2, dir, win);
   endtask

   // Expected {ball_reset, ball_en, game_over} for each state.
   function automatic logic [2:0] decode(input logic [2:0] st);
      case (st)
         S_IDLE:  decode = 3'b100;
         S_SERVE: decode = 3'b100;
         S_PLAY:  decode = 3'b010;
         S_POINT: decode = 3'b000;
         S_GO:    decode = 3'b101;
         default: decode = 3'b000;
      endcase
   endfunction

   task automatic check(input string name, input logic [2:0] st, input logic [3:0] p1, p2,
                        input logic dir, win);
      logic [2:0] d;
      logic [15:0] act, exp;
      d   = decode(st);
      act = {state, score_p1, score_p2, ball_reset, ball_en, serve_dir, game_over, winner};
      exp = {st, p1, p2, d[2], d[1], dir, d[0], win};
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got st=%0d p1=%0d p2=%0d brst=%b ben=%b dir=%b go=%b win=%b, need st=%0d p1=%0d p2=%0d brst=%b ben=%b dir=%b go=%b win=%b",
                    name, state, score_p1, score_p2, ball_reset, ball_en, serve_dir, game_over, winner,
                    st, p1, p2, d[2], d[1], dir, d[0], win);
   endtask

   initial begin
      // --- test 1: serve press through synchroniser, then 4 ticks to PLAY
      addn(2, 0,1,0,0,0, S_IDLE,  0,0,1,0);
      addn(3, 0,1,0,0,0, S_SERVE, 0,0,1,0);
      addn(3, 1,1,0,0,0, S_SERVE, 0,0,1,0);
      add (   1,1,1,0,0, S_SERVE, 0,0,1,0);
      add (   1,1,0,0,0, S_SERVE, 0,0,1,0);
      addn(2, 1,1,1,0,0, S_SERVE, 0,0,1,0);
      add (   1,1,1,0,0, S_PLAY,  0,0,1,0);
      add (   1,1,0,0,0, S_PLAY,  0,0,1,0);
      // serve presses in PLAY do nothing
      addn(3, 0,1,0,0,0, S_PLAY,  0,0,1,0);
      addn(3, 1,1,0,0,0, S_PLAY,  0,0,1,0);
      // --- test 2: miss_right with a coincident tick that must not count
      add (   1,1,1,0,1, S_POINT, 1,0,1,0);
      add (   1,1,0,1,0, S_POINT, 1,0,1,0);
      add (   1,1,1,0,0, S_POINT, 1,0,1,0);
      add (   1,1,1,0,0, S_SERVE, 1,0,1,0);
      addn(3, 1,1,1,0,0, S_SERVE, 1,0,1,0);
      add (   1,1,1,0,0, S_PLAY,  1,0,1,0);
      // --- test 3/4: left misses, one coinciding with miss_right
      add (   1,1,0,1,0, S_POINT, 1,1,0,0);
      add (   1,1,1,0,0, S_POINT, 1,1,0,0);
      add (   1,1,1,0,0, S_SERVE, 1,1,0,0);
      addn(3, 1,1,1,0,0, S_SERVE, 1,1,0,0);
      add (   1,1,1,0,0, S_PLAY,  1,1,0,0);
      add (   1,1,0,1,1, S_POINT, 1,2,0,0);
      add (   1,1,1,0,0, S_POINT, 1,2,0,0);
      add (   1,1,1,0,0, S_SERVE, 1,2,0,0);
      addn(3, 1,1,1,0,0, S_SERVE, 1,2,0,0);
      add (   1,1,1,0,0, S_PLAY,  1,2,0,0);
      add (   1,1,0,1,0, S_GO,    1,3,0,1);
      addn(3, 0,1,0,0,0, S_GO,    1,3,0,1);
      addn(3, 1,1,0,0,0, S_GO,    1,3,0,1);
      add (   1,1,1,1,1, S_GO,    1,3,0,1);
      add (   1,1,0,0,1, S_GO,    1,3,0,1);
      // --- test 5: restart from GAME_OVER, then mid-SERVE
      addn(2, 1,0,0,0,0, S_GO,    1,3,0,1);
      add (   1,0,0,0,0, S_IDLE,  0,0,1,0);
      addn(3, 1,1,0,0,0, S_IDLE,  0,0,1,0);
      addn(2, 0,1,0,0,0, S_IDLE,  0,0,1,0);
      add (   0,1,0,0,0, S_SERVE, 0,0,1,0);
      addn(3, 1,1,0,0,0, S_SERVE, 0,0,1,0);
      addn(2, 1,1,1,0,0, S_SERVE, 0,0,1,0);
      addn(2, 1,0,0,0,0, S_SERVE, 0,0,1,0);
      add (   1,0,0,0,0, S_IDLE,  0,0,1,0);
      addn(3, 1,1,0,0,0, S_IDLE,  0,0,1,0);
      addn(2, 0,1,0,0,0, S_IDLE,  0,0,1,0);
      add (   0,1,0,0,0, S_SERVE, 0,0,1,0);
      addn(3, 1,1,0,0,0, S_SERVE, 0,0,1,0);
      addn(3, 1,1,1,0,0, S_SERVE, 0,0,1,0);
      add (   1,1,1,0,0, S_PLAY,  0,0,1,0);
      // --- build a 2-1 score in PLAY for the async reset test
      add (   1,1,0,0,1, S_POINT, 1,0,1,0);
      add (   1,1,1,0,0, S_POINT, 1,0,1,0);
      add (   1,1,1,0,0, S_SERVE, 1,0,1,0);
      addn(3, 1,1,1,0,0, S_SERVE, 1,0,1,0);
      add (   1,1,1,0,0, S_PLAY,  1,0,1,0);
      add (   1,1,0,1,0, S_POINT, 1,1,0,0);
      add (   1,1,1,0,0, S_POINT, 1,1,0,0);
      add (   1,1,1,0,0, S_SERVE, 1,1,0,0);
      addn(3, 1,1,1,0,0, S_SERVE, 1,1,0,0);
      add (   1,1,1,0,0, S_PLAY,  1,1,0,0);
      add (   1,1,0,0,1, S_POINT, 2,1,1,0);
      add (   1,1,1,0,0, S_POINT, 2,1,1,0);
      add (   1,1,1,0,0, S_SERVE, 2,1,1,0);
      addn(3, 1,1,1,0,0, S_SERVE, 2,1,1,0);
      add (   1,1,1,0,0, S_PLAY,  2,1,1,0);
      add (   1,1,0,0,0, S_PLAY,  2,1,1,0);

      rst           = 1'b1;
      frame_tick    = 1'b0;
      serve_btn_n   = 1'b1;
      restart_btn_n = 1'b1;
      miss_left     = 1'b0;
      miss_right    = 1'b0;
      #1 rst = 1'b0;
      #2 check("reset_state", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         serve_btn_n   = vq[i].sn;
         restart_btn_n = vq[i].rn;
         frame_tick    = vq[i].tk;
         miss_left     = vq[i].ml;
         miss_right    = vq[i].mr;
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), vq[i].st, vq[i].p1, vq[i].p2, vq[i].dir, vq[i].win);
      end

      // --- test 6: async reset mid-cycle in PLAY at 2-1, no clock edge needed
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check("async_reset_now", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1 check("async_reset_held", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 check("after_reset_release", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
